uart_mmio: RTL and testbench
============================

UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width matching the core.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1000_0000, 16-byte-aligned register window base.
REQ-003 SHALL have parameter CLK_DIV, default 16, reset value of the baud divisor (clocks per bit, range 4..65535).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two, 2..64).
REQ-005 clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately.
REQ-007 mem_load  input  1  core MEM-stage load strobe.
REQ-008 mem_store  input  1  core MEM-stage store strobe.
REQ-009 address  input  XLEN  core MEM-stage byte address.
REQ-010 store_data  input  XLEN  core store data; only bits [15:0] are used.
REQ-011 load_data  output  XLEN  read data, combinational from address in the same cycle.
REQ-012 tx  output  1  serial transmit line, idle high.
REQ-013 rx  input  1  asynchronous serial receive line.

Function
REQ-014 SHALL decode "sel" when address[XLEN-1:4] == BASE_ADDR[XLEN-1:4]; register index = address[3:2].
REQ-015 SHALL drive load_data = 0 when sel is 0, or when index is 3.
REQ-016 DATA (idx 0) store SHALL push store_data[7:0] into the TX FIFO if count < FIFO_DEPTH before the edge; otherwise it SHALL drop the byte and set tx_ovf.
REQ-017 DATA load SHALL return {zeros, rx_data[7:0]} and clear rx_valid at the edge.
REQ-018 STATUS (idx 1) load SHALL return bit0 tx_full, bit1 tx_idle (FIFO empty and FSM IDLE), bit2 rx_valid, bit3 tx_ovf, bit4 rx_ovr, bit5 rx_ferr, all other bits 0.
REQ-019 STATUS store SHALL clear each of bits 3..5 whose store_data bit is 1 (write-1-to-clear); other bits SHALL be ignored.
REQ-020 DIV (idx 2) load/store SHALL access the 16-bit divisor; stored values below 4 SHALL be written as 4.
REQ-021 Simultaneous push and pop on a non-full FIFO SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-022 TX FSM states SHALL be IDLE, START, DATA, STOP; each non-IDLE bit SHALL last exactly div clocks.
REQ-023 In IDLE with FIFO non-empty, the FSM SHALL pop one byte and enter START on the next edge (tx=0).
REQ-024 DATA SHALL shift 8 bits LSB first; STOP SHALL drive tx=1.
REQ-025 At the end of STOP, the FSM SHALL pop and go directly to START if the FIFO is non-empty, else go to IDLE (no idle gap between back-to-back bytes).
REQ-026 rx SHALL pass through a 2-flop synchronizer before use.
REQ-027 RX on a falling edge SHALL wait div/2 clocks; if the line is high, it SHALL return to idle (glitch rejection); otherwise it SHALL sample 8 data bits then the stop bit, each div clocks apart.
REQ-028 On a high stop bit, RX SHALL load rx_data and set rx_valid; if rx_valid was already 1, it SHALL also set rx_ovr and overwrite.
REQ-029 On a low stop bit, RX SHALL discard the byte and set rx_ferr.
REQ-030 If an RX completion and a DATA load occur in the same cycle, rx_valid SHALL end at 1 holding the new byte, with no rx_ovr.
REQ-031 A DIV write SHALL take effect at the next bit boundary; an in-progress bit SHALL finish with the old divisor.
REQ-032 Strobes with sel=0, and stores to index 3, SHALL have no effect.

Reset
REQ-033 On reset=0: tx=1, FIFO empty, TX/RX FSMs idle, rx_data=0, rx_valid=0, tx_ovf=rx_ovr=rx_ferr=0, div=CLK_DIV.
REQ-034 On reset=0, load_data SHALL still follow REQ-015/018 combinationally (STATUS reads 0x2).
REQ-035 Reset asserted mid-frame SHALL immediately abort TX (tx=1) and RX, and discard FIFO contents.

Verification
REQ-036 Reset, then read STATUS -> 0x00000002; read DIV -> 16.
REQ-037 DIV=4, store 0x55 to DATA -> tx low 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks; STATUS bit1 returns to 1.
REQ-038 Store 9 bytes back-to-back with the TX FSM busy, FIFO_DEPTH=8 -> tx_full=1, tx_ovf=1, exactly 9 frames sent (1 in shifter + 8), no gaps; W1C 0x8 clears tx_ovf.
REQ-039 Loopback tx->rx, DIV=4, send 0xA3 -> rx_valid=1, DATA reads 0x000000A3, then rx_valid=0.
REQ-040 Loopback, send 0x11 and 0x22 without reading -> DATA=0x22, rx_ovr=1; a frame driven with stop=0 -> rx_ferr=1, rx_valid unchanged.
REQ-041 Assert reset during the DATA phase of a TX frame -> tx=1 the same cycle, STATUS=0x2 after release, no residual frame.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART for a single-issue core.
//
// Register window (16 bytes at BASE_ADDR, word index = address[3:2]):
//   0 DATA   store pushes a byte into the TX FIFO; load returns rx_data and
//            consumes it (clears rx_valid)
//   1 STATUS {rx_ferr, rx_ovr, tx_ovf, rx_valid, tx_idle, tx_full} in [5:0];
//            bits 3..5 are write-1-to-clear
//   2 DIV    16-bit clocks-per-bit divisor, writes below 4 saturate to 4
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   clock, reset        sole clock; asynchronous active-low reset
//   mem_load, mem_store MEM-stage strobes, each a single-cycle request that
//                       is accepted unconditionally at the rising edge (no
//                       back-pressure; a store to a full FIFO is dropped and
//                       flagged in tx_ovf)
//   address, store_data MEM-stage byte address and store data ([15:0] used)
//   load_data           combinational read data for the addressed register
//   tx, rx              serial line out (idle high) / asynchronous line in
//   tx_state_dbg        current TX FSM state (IDLE, START, DATA, STOP)
//   rx_state_dbg        current RX FSM state (IDLE, START, DATA, STOP)
module uart_mmio #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  BASE_ADDR  = 32'h1000_0000,
  parameter int               CLK_DIV    = 16,
  parameter int               FIFO_DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            tx,
  input  logic            rx,
  output logic [1:0]      tx_state_dbg,
  output logic [1:0]      rx_state_dbg
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Register decode
  logic       sel;
  logic [1:0] idx;
  logic       wr_data, rd_data, wr_stat, wr_div;

  assign sel     = (address[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign idx     = address[3:2];
  assign wr_data = mem_store && sel && (idx == 2'd0);
  assign rd_data = mem_load  && sel && (idx == 2'd0);
  assign wr_stat = mem_store && sel && (idx == 2'd1);
  assign wr_div  = mem_store && sel && (idx == 2'd2);

  logic unused_bits;
  assign unused_bits = ^{store_data[XLEN-1:16], address[1:0]};

  // Control/status state
  logic [15:0] div;
  logic [7:0]  rx_data;
  logic        rx_valid, tx_ovf, rx_ovr, rx_ferr;

  // TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          tx_full, push, pop;

  // TX FSM
  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;

  // RX FSM; rx_s3 is the previous synchronized sample for edge detection
  rx_state_t   rx_state;
  logic        rx_s1, rx_s2, rx_s3;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_done_ok, rx_done_bad;

  assign tx_full = (count == DEPTH_C);
  assign push    = wr_data && !tx_full;
  // The FSM takes a byte either from IDLE or at the end of a stop bit, so
  // consecutive frames follow with no idle gap.
  assign pop = (count != '0) &&
               ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == 16'd0));

  assign rx_done_ok  = (rx_state == RX_STOP) && (rx_cnt == 16'd0) &&  rx_s2;
  assign rx_done_bad = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && !rx_s2;

  assign tx_state_dbg = tx_state;
  assign rx_state_dbg = rx_state;

  always_comb begin
    load_data = '0;
    if (sel) begin
      case (idx)
        2'd0:    load_data[7:0]  = rx_data;
        2'd1:    load_data[5:0]  = {rx_ferr, rx_ovr, tx_ovf, rx_valid,
                                    (count == '0) && (tx_state == TX_IDLE), tx_full};
        2'd2:    load_data[15:0] = div;
        default: load_data       = '0;
      endcase
    end
  end

  // FIFO storage needs no reset: an empty count makes its contents invisible.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= store_data[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div      <= 16'(CLK_DIV);
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      if (wr_stat) begin
        if (store_data[3]) tx_ovf  <= 1'b0;
        if (store_data[4]) rx_ovr  <= 1'b0;
        if (store_data[5]) rx_ferr <= 1'b0;
      end
      if (wr_data && tx_full) tx_ovf <= 1'b1;
      if (wr_div) div <= (store_data[15:0] < 16'd4) ? 16'd4 : store_data[15:0];
      // A completing byte wins over a same-cycle DATA read; that read
      // consumed the old byte, so it is not an overrun.
      if (rx_done_ok) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_data) rx_ovr <= 1'b1;
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end
      if (rx_done_bad) rx_ferr <= 1'b1;
    end
  end

  // Each bit reloads tx_cnt from div, so a divisor write only affects the
  // next bit to start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'd0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            tx_sh    <= fifo_mem[rd_ptr];
            tx       <= 1'b0;
            tx_cnt   <= div - 16'd1;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == 16'd0) begin
            tx       <= tx_sh[0];
            tx_bit   <= 3'd0;
            tx_cnt   <= div - 16'd1;
            tx_state <= TX_DATA;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        TX_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= div - 16'd1;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx_sh  <= tx_sh >> 1;
              tx     <= tx_sh[1];
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        default: begin // TX_STOP
          if (tx_cnt == 16'd0) begin
            if (pop) begin
              tx_sh    <= fifo_mem[rd_ptr];
              tx       <= 1'b0;
              tx_cnt   <= div - 16'd1;
              tx_state <= TX_START;
            end else tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'd0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_cnt   <= (div >> 1) - 16'd1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          // Mid start bit: a line back high was a glitch, not a frame.
          if (rx_cnt == 16'd0) begin
            if (rx_s2) rx_state <= RX_IDLE;
            else begin
              rx_cnt   <= div - 16'd1;
              rx_bit   <= 3'd0;
              rx_state <= RX_DATA;
            end
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= div - 16'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        default: begin // RX_STOP
          if (rx_cnt == 16'd0) rx_state <= RX_IDLE;
          else rx_cnt <= rx_cnt - 16'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed tests for uart_mmio. tx is logged once per clock on
// the falling edge; frames are compared against 40-sample expected waveforms
// (DIV=4: start, 8 data bits LSB first, stop, 4 samples each).
module tb_uart_mmio;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DIV  = BASE + 32'h8;
  localparam logic [31:0] A_RSV  = BASE + 32'hC;
  localparam logic [31:0] A_OUT  = BASE + 32'h10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        tx;
  logic        rx;
  logic [1:0]  tx_state_dbg;
  logic [1:0]  rx_state_dbg;

  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;
  assign rx = loop_en ? tx : rx_drv;

  int n_pass  = 0;
  int n_total = 0;

  logic tx_log[$];

  uart_mmio #(.XLEN(32), .BASE_ADDR(32'h1000_0000), .CLK_DIV(16), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .mem_load(mem_load), .mem_store(mem_store),
    .address(address), .store_data(store_data), .load_data(load_data),
    .tx(tx), .rx(rx), .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
  );

  // clock/reset block
  always #5 clock = ~clock;
  always @(negedge clock) tx_log.push_back(tx);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    address = a; store_data = d; mem_store = 1'b1;
    @(posedge clock); #1;
    mem_store = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    @(negedge clock);
    address = a; mem_load = 1'b1;
    #1 d = load_data;
    @(posedge clock); #1;
    mem_load = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clock); rx_drv = 1'b0; repeat (4) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i]; repeat (4) @(negedge clock);
    end
    rx_drv = stop_bit; repeat (4) @(negedge clock);
    rx_drv = 1'b1;
  endtask

  function automatic int find_start(input int from, input int bound);
    for (int i = from; i < from + bound && i < tx_log.size(); i++)
      if (tx_log[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic logic [39:0] frame_at(input int s);
    logic [39:0] v;
    for (int i = 0; i < 40; i++)
      v[i] = (s >= 0 && s + i < tx_log.size()) ? tx_log[s+i] : 1'bx;
    return v;
  endfunction

  function automatic logic [39:0] frame_exp(input logic [7:0] b);
    logic [39:0] v;
    for (int i = 0; i < 40; i++) begin
      int p;
      p = i / 4;
      if (p == 0) v[i] = 1'b0;
      else if (p <= 8) v[i] = b[p-1];
      else v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic int count_low(input int from, input int to);
    int n;
    n = 0;
    for (int i = from; i < to && i < tx_log.size(); i++)
      if (tx_log[i] !== 1'b1) n++;
    return n;
  endfunction

  // tests
  task automatic test_reset;
    logic [31:0] r;
    reset = 1'b0;
    wait_cycles(2); #1;
    n_total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL reset_status_in_reset: got %h want 00000002", r); else n_pass++;
    @(negedge clock); reset = 1'b1;
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL reset_status: got %h want 00000002", r); else n_pass++;
    do_load(A_DIV, r);
    n_total++; if (r !== 32'd16) $display("FAIL reset_div: got %h want 00000010", r); else n_pass++;
    do_load(A_DATA, r);
    n_total++; if (r !== 32'h0) $display("FAIL reset_data: got %h want 00000000", r); else n_pass++;
    do_load(A_RSV, r);
    n_total++; if (r !== 32'h0) $display("FAIL reserved_read: got %h want 00000000", r); else n_pass++;
    do_load(A_OUT + 32'h4, r);
    n_total++; if (r !== 32'h0) $display("FAIL unselected_read: got %h want 00000000", r); else n_pass++;
    n_total++; if (tx_state_dbg !== 2'd0) $display("FAIL reset_tx_state: got %0d want 0", tx_state_dbg); else n_pass++;
  endtask

  task automatic test_div_and_decode;
    logic [31:0] r;
    do_store(A_DIV, 32'd2);
    do_load(A_DIV, r);
    n_total++; if (r !== 32'd4) $display("FAIL div_saturate: got %h want 00000004", r); else n_pass++;
    do_store(A_DIV, 32'hABCD_012C);
    do_load(A_DIV, r);
    n_total++; if (r !== 32'h012C) $display("FAIL div_write: got %h want 0000012c", r); else n_pass++;
    do_store(A_DIV, 32'd4);
    do_store(A_OUT + 32'h8, 32'd9);
    do_store(A_RSV, 32'hFF);
    do_load(A_DIV, r);
    n_total++; if (r !== 32'd4) $display("FAIL div_ignores_unselected: got %h want 00000004", r); else n_pass++;
    do_store(A_OUT, 32'h5A);
    wait_cycles(4);
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL unselected_data_store: got %h want 00000002", r); else n_pass++;
  endtask

  task automatic test_tx_frame;
    logic [31:0] r;
    int l, s;
    do_store(A_DATA, 32'h55);
    l = tx_log.size();
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h0) $display("FAIL tx_busy_status: got %h want 00000000", r); else n_pass++;
    wait_cycles(45);
    s = find_start(l, 8);
    n_total++; if (s != l + 1) $display("FAIL tx_start_latency: got index %0d want %0d", s, l + 1); else n_pass++;
    n_total++; if (frame_at(s) !== frame_exp(8'h55))
      $display("FAIL tx_frame_55: got %h want %h", frame_at(s), frame_exp(8'h55)); else n_pass++;
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL tx_idle_after: got %h want 00000002", r); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    int l, s, z;
    do_store(A_DATA, 32'hC0);
    l = tx_log.size();
    for (int k = 1; k <= 9; k++) do_store(A_DATA, 32'hC0 + k);
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h9) $display("FAIL full_ovf_status: got %h want 00000009", r); else n_pass++;
    do_store(A_STAT, 32'h8);
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h1) $display("FAIL ovf_w1c: got %h want 00000001", r); else n_pass++;
    wait_cycles(9 * 40 + 40);
    s = find_start(l, 8);
    n_total++; if (s != l + 1) $display("FAIL b2b_start_latency: got index %0d want %0d", s, l + 1); else n_pass++;
    for (int f = 0; f < 9; f++) begin
      logic [7:0] b;
      b = 8'hC0 + 8'(f);
      n_total++; if (frame_at(s + 40*f) !== frame_exp(b))
        $display("FAIL b2b_frame_%0d: got %h want %h", f, frame_at(s + 40*f), frame_exp(b)); else n_pass++;
    end
    z = count_low(s + 360, s + 400);
    n_total++; if (z != 0) $display("FAIL b2b_extra_frame: got %0d low samples want 0", z); else n_pass++;
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL b2b_idle_status: got %h want 00000002", r); else n_pass++;
  endtask

  task automatic test_loopback;
    logic [31:0] r;
    loop_en = 1'b1;
    do_store(A_DATA, 32'hA3);
    wait_cycles(70);
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h6) $display("FAIL lb_valid_status: got %h want 00000006", r); else n_pass++;
    do_load(A_DATA, r);
    n_total++; if (r !== 32'hA3) $display("FAIL lb_data: got %h want 000000a3", r); else n_pass++;
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL lb_valid_cleared: got %h want 00000002", r); else n_pass++;
  endtask

  task automatic test_overrun;
    logic [31:0] r;
    do_store(A_DATA, 32'h11);
    do_store(A_DATA, 32'h22);
    wait_cycles(120);
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h16) $display("FAIL ovr_status: got %h want 00000016", r); else n_pass++;
    do_load(A_DATA, r);
    n_total++; if (r !== 32'h22) $display("FAIL ovr_data: got %h want 00000022", r); else n_pass++;
    do_store(A_STAT, 32'h10);
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL ovr_w1c: got %h want 00000002", r); else n_pass++;
  endtask

  task automatic test_framing;
    logic [31:0] r;
    do_store(A_DATA, 32'h5A);
    wait_cycles(70);
    loop_en = 1'b0;
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h6) $display("FAIL ferr_pre_status: got %h want 00000006", r); else n_pass++;
    drive_rx_frame(8'hF0, 1'b0);
    wait_cycles(10);
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h26) $display("FAIL ferr_status: got %h want 00000026", r); else n_pass++;
    do_load(A_DATA, r);
    n_total++; if (r !== 32'h5A) $display("FAIL ferr_data_kept: got %h want 0000005a", r); else n_pass++;
    do_store(A_STAT, 32'h20);
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL ferr_w1c: got %h want 00000002", r); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] r;
    int l, z;
    do_store(A_DATA, 32'h00);
    do_store(A_DATA, 32'h00);
    do_store(A_DATA, 32'h00);
    wait_cycles(10);
    @(negedge clock);
    n_total++; if (tx !== 1'b0) $display("FAIL mid_frame_tx_low: got %b want 0", tx); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (tx !== 1'b1) $display("FAIL reset_abort_tx: got %b want 1", tx); else n_pass++;
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL reset_abort_status: got %h want 00000002", r); else n_pass++;
    @(negedge clock); reset = 1'b1;
    l = tx_log.size();
    wait_cycles(100);
    z = count_low(l, l + 100);
    n_total++; if (z != 0) $display("FAIL reset_residual_frame: got %0d low samples want 0", z); else n_pass++;
    do_load(A_STAT, r);
    n_total++; if (r !== 32'h2) $display("FAIL reset_release_status: got %h want 00000002", r); else n_pass++;
    do_load(A_DIV, r);
    n_total++; if (r !== 32'd16) $display("FAIL reset_release_div: got %h want 00000010", r); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_div_and_decode;
    test_tx_frame;
    test_back_to_back;
    test_loopback;
    test_overrun;
    test_framing;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
